spart_tx_fifo: RTL



---
 rtl/spart_pkg.sv | 15 +
 rtl/spart_sync_fifo.sv | 59 +++++
 rtl/spart_tx_fifo.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/spart_pkg.sv
// Shared SPART definitions: serial FSM state encoding and line idle level.
// Used by both the transmit and receive paths.
package spart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } spart_state_e;

    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/spart_sync_fifo.sv
// Single-clock circular FIFO with occupancy counter and combinational head read.
// A push while full is accepted only when a pop frees the slot in the same cycle.
module spart_sync_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign rd_ok   = pop && !empty;
    assign wr_ok   = push && (!full || rd_ok);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/spart_tx_fifo.sv
// SPART transmitter: buffers bus writes in a FIFO and serialises them LSB-first
// on txd, one bit per baud_tick, with optional parity and 1 or 2 stop bits.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | line high, waiting for a tick with data queued
//   START  | driving the start bit (0)
//   DATA   | driving shift[0]; bit_cnt counts data bits sent
//   PARITY | driving the parity bit computed when the byte was loaded
//   STOP   | line high; stop_cnt counts the first of two stop bits
module spart_tx_fifo
    import spart_pkg::*;
#(
    parameter  int DATA_BITS  = 8,
    parameter  int FIFO_DEPTH = 8,
    localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 cfg_par_en,
    input  logic                 cfg_par_odd,
    input  logic                 cfg_two_stop,
    input  logic                 ovf_clr,
    output logic                 txd,
    output logic                 tbr,
    output logic                 tx_busy,
    output logic [CW-1:0]        fifo_count,
    output logic                 overflow
);

    localparam int BW = $clog2(DATA_BITS);

    spart_state_e         state_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [BW-1:0]        bit_cnt_q;
    logic                 stop_cnt_q;
    logic                 par_bit_q;
    logic                 par_en_q;
    logic                 two_stop_q;

    logic                 fifo_full;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_head;
    logic                 stop_more;
    logic                 pop;
    logic                 ovf_set;

    spart_sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (wr_en),
        .wr_data (wr_data),
        .pop     (pop),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // A second stop bit is still owed: the frame cannot hand over yet.
    assign stop_more = two_stop_q && !stop_cnt_q;

    assign pop = baud_tick && !fifo_empty &&
                 ((state_q == IDLE) || ((state_q == STOP) && !stop_more));

    assign ovf_set = wr_en && fifo_full && !pop;
    assign tx_busy = (state_q != IDLE) || (fifo_count != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            txd        <= IDLE_LEVEL;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_bit_q  <= 1'b0;
            par_en_q   <= 1'b0;
            two_stop_q <= 1'b0;
        end else if (pop) begin
            // Frame config is frozen here so later cfg_* writes cannot corrupt it.
            state_q    <= START;
            txd        <= 1'b0;
            shift_q    <= fifo_head;
            par_bit_q  <= (^fifo_head) ^ cfg_par_odd;
            par_en_q   <= cfg_par_en;
            two_stop_q <= cfg_two_stop;
        end else if (baud_tick) begin
            case (state_q)
                IDLE: begin
                    txd <= IDLE_LEVEL;
                end
                START: begin
                    state_q   <= DATA;
                    bit_cnt_q <= '0;
                    txd       <= shift_q[0];
                end
                DATA: begin
                    shift_q   <= shift_q >> 1;
                    bit_cnt_q <= bit_cnt_q + BW'(1);
                    if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
                        if (par_en_q) begin
                            state_q <= PARITY;
                            txd     <= par_bit_q;
                        end else begin
                            state_q    <= STOP;
                            stop_cnt_q <= 1'b0;
                            txd        <= IDLE_LEVEL;
                        end
                    end else begin
                        txd <= shift_q[1];
                    end
                end
                PARITY: begin
                    state_q    <= STOP;
                    stop_cnt_q <= 1'b0;
                    txd        <= IDLE_LEVEL;
                end
                STOP: begin
                    txd <= IDLE_LEVEL;
                    if (stop_more) begin
                        stop_cnt_q <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    txd     <= IDLE_LEVEL;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tbr <= 1'b1;
        end else begin
            tbr <= (fifo_count != CW'(FIFO_DEPTH));
        end
    end

    // A dropped write in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (ovf_set) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule
